// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared digit width and seven-segment patterns {a,b,c,d,e,f,g}, a as MSB
package bcd_display_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_seg_decoder.sv
// rtl/bcd_seg_decoder.sv - combinational BCD to seven-segment decoder; codes 10..15 decode blank
module bcd_seg_decoder
    import bcd_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_code,
    output logic [6:0]         o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - multiplexed BCD display scanner with frame-coherent updates
// Optional leading-zero blanking: define BCD_LEADING_ZERO_BLANK_EN.
module bcd_scan_display
    import bcd_display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [DIGIT_W*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]           dp_in,
    input  logic                        load,
    output logic [6:0]                  segment,
    output logic                        dp,
    output logic [DIGITS-1:0]           digit_en,
    output logic                        frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [PS_W-1:0]           r_presc;
    logic [IDX_W-1:0]          r_idx;
    logic [DIGIT_W*DIGITS-1:0] r_pend_bcd;
    logic [DIGITS-1:0]         r_pend_dp;
    logic                      r_pend_valid;
    logic [DIGIT_W*DIGITS-1:0] r_act_bcd;
    logic [DIGITS-1:0]         r_act_dp;
    logic                      r_wrap_d;

    logic                      w_tick;
    logic                      w_wrap;
    logic [DIGITS-1:0]         w_onehot;
    logic [DIGIT_W-1:0]        w_code;
    logic                      w_dp;
    logic [6:0]                w_seg;
    logic                      w_blank;

    assign w_tick = (r_presc == PS_MAX);
    assign w_wrap = w_tick && (r_idx == IDX_MAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
            if (w_tick) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // Loads land in pending; active only changes on the frame wrap, so a frame never tears.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_bcd   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_act_bcd    <= '0;
            r_act_dp     <= '0;
        end else begin
            if (load) begin
                r_pend_bcd <= bcd_in;
                r_pend_dp  <= dp_in;
            end
            if (w_wrap) begin
                r_pend_valid <= 1'b0;
                if (load) begin
                    r_act_bcd <= bcd_in;
                    r_act_dp  <= dp_in;
                end else if (r_pend_valid) begin
                    r_act_bcd <= r_pend_bcd;
                    r_act_dp  <= r_pend_dp;
                end
            end else if (load) begin
                r_pend_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        w_code   = '0;
        w_dp     = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_onehot[k] = 1'b1;
                w_code      = r_act_bcd[k*DIGIT_W +: DIGIT_W];
                w_dp        = r_act_dp[k];
            end
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] w_lead_zero;

    // w_lead_zero[k] is set when digit k and every digit above it are zero.
    always_comb begin
        logic run;
        run         = 1'b1;
        w_lead_zero = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run            = run && (r_act_bcd[k*DIGIT_W +: DIGIT_W] == '0);
            w_lead_zero[k] = run;
        end
    end

    assign w_blank = (r_idx != '0) && |(w_lead_zero & w_onehot);
`else
    assign w_blank = 1'b0;
`endif

    bcd_seg_decoder u_dec (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wrap_d    <= 1'b0;
            segment     <= SEG_BLANK;
            dp          <= 1'b0;
            digit_en    <= '0;
            frame_start <= 1'b0;
        end else begin
            r_wrap_d    <= w_wrap;
            segment     <= w_blank ? SEG_BLANK : w_seg;
            dp          <= w_dp;
            digit_en    <= w_onehot;
            frame_start <= r_wrap_d;
        end
    end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of multiplexed BCD digits (legal range 1..8).
REQ-002 SHALL have parameter PRESCALE, default 1000, giving clock cycles per digit slot (legal range >=1).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state is rising-edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port bcd_in, input, 4*DIGITS bits: digit k in bits [4k+3:4k], where digit 0 is least significant.
REQ-006 SHALL have port dp_in, input, DIGITS bits: decimal point per digit.
REQ-007 SHALL have port load, input, 1 bit: strobe that captures bcd_in and dp_in.
REQ-008 SHALL have port segment, output, 7 bits: segments {a,b,c,d,e,f,g} with a as MSB, active-high.
REQ-009 SHALL have port dp, output, 1 bit: decimal point of the scanned digit, active-high.
REQ-010 SHALL have port digit_en, output, DIGITS bits: one-hot, active-high select of the scanned digit.
REQ-011 SHALL have port frame_start, output, 1 bit: one-cycle pulse when scanning enters digit 0.

Function
REQ-012 SHALL count with a prescaler 0..PRESCALE-1; tick is asserted when the count equals PRESCALE-1, and the count wraps to 0 on that cycle.
REQ-013 SHALL advance the scan index on each tick (0 -> 1 -> ... -> DIGITS-1 -> 0); when PRESCALE=1 a tick occurs every cycle.
REQ-014 SHALL hold captured data in two registers: pending (written by load) and active (displayed), plus a pending_valid flag.
REQ-015 SHALL, when load is sampled high, write bcd_in/dp_in to pending and set pending_valid; a later load before commit overwrites pending, so the latest load wins.
REQ-016 SHALL commit pending to active and clear pending_valid on the tick where the index wraps from DIGITS-1 to 0; updates are frame-coherent, with no mid-frame tearing.
REQ-017 SHALL, when load coincides with the commit tick, commit the new bcd_in/dp_in directly to active and leave pending_valid clear.
REQ-018 SHALL register segment, dp, digit_en and frame_start, and update them one clock after the index changes; the outputs are never combinational from inputs.
REQ-019 SHALL set digit_en to the one-hot of the index and segment to the decoded active digit at that index.
REQ-020 SHALL decode 0..9 as: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
REQ-021 SHALL drive segment 0000000 for codes 10..15, while dp still follows active dp.
REQ-022 SHALL pulse frame_start high for exactly one cycle, coincident with the first registered output cycle of digit 0 in each frame.

Reset
REQ-023 SHALL, while reset_n is low, immediately force prescaler=0, index=0, pending=0, active=0, pending_valid=0, segment=0000000, dp=0, digit_en=0 and frame_start=0.
REQ-024 SHALL, on the first edge after reset_n releases, drive digit_en=...0001 and segment=1111110, with no frame_start pulse for this initial frame.
REQ-025 SHALL discard any pending load when reset asserts mid-frame.

Configuration
REQ-026 SHALL, when macro BCD_LEADING_ZERO_BLANK_EN is defined, blank (segment 0000000, dp unchanged) every zero digit more significant than the highest non-zero digit; digit 0 is never blanked.
REQ-027 SHALL, when BCD_LEADING_ZERO_BLANK_EN is undefined, display all zero digits as 1111110.

Structure
REQ-028 SHALL place the segment pattern constants (SEG_0..SEG_9, SEG_BLANK) and the DIGIT_W=4 constant in shared package bcd_display_pkg.
REQ-029 SHALL implement decoding in sub-module bcd_seg_decoder (4-bit code in, 7-bit pattern out, combinational), instantiated once on the indexed digit.

Verification (DIGITS=4, PRESCALE=4)
REQ-030 SHALL cover reset: assert reset_n low mid-frame -> all outputs 0 in the same cycle; release -> digit_en=0001 and segment=1111110 next edge.
REQ-031 SHALL cover commit: load bcd_in=0x1234 -> after the next wrap, digit_en=0001 gives 0110011 ("4") and digit_en=1000 gives 0110000 ("1").
REQ-032 SHALL cover invalid code: load 0x0A00 -> digit 2 shows 0000000; digits 0, 1 and 3 show 1111110 (macro off).
REQ-033 SHALL cover overwrite: load 0x1111 then 0x2222 in the same frame -> the next frame shows only 1101101 on all digits, and 0x1111 never appears.
REQ-034 SHALL cover collision: load 0x0009 on the wrap tick -> that frame shows digit 0 = 1111011.
REQ-035 SHALL cover blanking (macro on): load 0x0050 with dp_in=0100 -> digits 3 and 2 give segment 0000000, with dp=1 on digit 2; digit 1 gives 1011011; digit 0 gives 1111110.
